// File: rtl/move_apply_if.sv
// Command/result bundle for move_apply: board commands in, updated board and status out.
interface move_apply_if;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_cmd;
    logic [17:0]  in_move;
    logic [255:0] in_board;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_board;
    logic [3:0]   out_captured;
    logic         out_err;
    logic [4:0]   depth;

    modport master (
        output in_valid, in_cmd, in_move, in_board, out_ready,
        input  in_ready, out_valid, out_board, out_captured, out_err, depth
    );

    modport slave (
        input  in_valid, in_cmd, in_move, in_board, out_ready,
        output in_ready, out_valid, out_board, out_captured, out_err, depth
    );
endinterface

// File: rtl/move_apply.sv
// Applies and reverts chess moves on a 64-square board register, keeping an undo
// stack of {move, captured piece} so every DO can be exactly reversed by UNDO.
module move_apply #(
    parameter int STACK_DEPTH = 8
) (
    input logic         clk,
    input logic         reset,
    move_apply_if.slave bus
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0] FULL_DEPTH = 5'(STACK_DEPTH);
    localparam logic [1:0] CMD_DO   = 2'd1;
    localparam logic [1:0] CMD_UNDO = 2'd2;
    localparam logic [2:0] KIND_KING  = 3'd1;
    localparam logic [2:0] KIND_QUEEN = 3'd2;
    localparam logic [2:0] KIND_EP    = 3'd3;

    typedef enum logic [1:0] {IDLE, STEP1, STEP2, OUT} state_t;

    typedef struct packed {
        logic [17:0] mv;
        logic [3:0]  cap;
    } entry_t;

    state_t       state_q, state_d;
    logic [255:0] board_q, board_d;
    logic [4:0]   depth_q, depth_d;
    logic         is_undo_q, is_undo_d;
    logic [17:0]  move_q, move_d;
    logic [3:0]   cap_q, cap_d;
    logic [3:0]   out_captured_q, out_captured_d;
    logic         out_err_q, out_err_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;

    entry_t stack_q [STACK_DEPTH];
    logic             push_en;
    entry_t           push_entry;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    entry_t           top;

    logic [5:0]   from_sq, to_sq, ep_sq;
    logic [2:0]   promo, kind;
    logic [5:0]   u_from, u_to;
    logic [2:0]   u_promo, u_kind;
    logic [255:0] nb;
    logic [3:0]   piece, cap;

    function automatic logic [3:0] sq(input logic [255:0] b, input logic [5:0] i);
        return b[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [255:0] set_sq(input logic [255:0] b, input logic [5:0] i,
                                            input logic [3:0] v);
        logic [255:0] r;
        r = b;
        r[{i, 2'b00} +: 4] = v;
        return r;
    endfunction

    function automatic logic two_step(input logic [2:0] k);
        return (k == KIND_KING) || (k == KIND_QUEEN) || (k == KIND_EP);
    endfunction

    assign from_sq = move_q[17:12];
    assign to_sq   = move_q[11:6];
    assign promo   = move_q[5:3];
    assign kind    = move_q[2:0];
    // En-passant victim sits on the mover's rank, in the destination file.
    assign ep_sq   = {from_sq[5:3], to_sq[2:0]};

    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - 5'd1);
    assign top      = stack_q[top_idx];
    assign u_from   = top.mv[17:12];
    assign u_to     = top.mv[11:6];
    assign u_promo  = top.mv[5:3];
    assign u_kind   = top.mv[2:0];

    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        depth_d        = depth_q;
        is_undo_d      = is_undo_q;
        move_d         = move_q;
        cap_d          = cap_q;
        out_captured_d = out_captured_q;
        out_err_d      = out_err_q;
        out_valid_d    = out_valid_q;
        in_ready_d     = in_ready_q;
        push_en        = 1'b0;
        push_entry     = '{mv: move_q, cap: cap_q};
        nb             = board_q;
        piece          = 4'd0;
        cap            = 4'd0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_ready_d = 1'b0;
                    out_err_d  = 1'b0;
                    move_d     = bus.in_move;
                    case (bus.in_cmd)
                        CMD_DO: begin
                            is_undo_d = 1'b0;
                            if (depth_q == FULL_DEPTH) begin
                                out_err_d   = 1'b1;
                                out_valid_d = 1'b1;
                                state_d     = OUT;
                            end else begin
                                state_d = STEP1;
                            end
                        end
                        CMD_UNDO: begin
                            is_undo_d = 1'b1;
                            if (depth_q == 5'd0) begin
                                out_err_d   = 1'b1;
                                out_valid_d = 1'b1;
                                state_d     = OUT;
                            end else begin
                                state_d = STEP1;
                            end
                        end
                        default: begin
                            board_d        = bus.in_board;
                            depth_d        = 5'd0;
                            out_captured_d = 4'd0;
                            out_valid_d    = 1'b1;
                            state_d        = OUT;
                        end
                    endcase
                end
            end

            STEP1: begin
                if (!is_undo_q) begin
                    cap   = (kind == KIND_EP) ? sq(board_q, ep_sq) : sq(board_q, to_sq);
                    piece = sq(board_q, from_sq);
                    nb    = set_sq(board_q, to_sq, (promo != 3'd0) ? {piece[3], promo} : piece);
                    nb    = set_sq(nb, from_sq, 4'd0);
                    board_d = nb;
                    cap_d   = cap;
                    if (two_step(kind)) begin
                        state_d = STEP2;
                    end else begin
                        push_en        = 1'b1;
                        push_entry     = '{mv: move_q, cap: cap};
                        depth_d        = depth_q + 5'd1;
                        out_captured_d = cap;
                        out_valid_d    = 1'b1;
                        state_d        = OUT;
                    end
                end else begin
                    // The popped move replaces move_q so STEP2 can finish the revert.
                    piece = sq(board_q, u_to);
                    nb    = set_sq(board_q, u_from,
                                   (u_promo != 3'd0) ? {piece[3], 3'd1} : piece);
                    nb    = set_sq(nb, u_to, (u_kind == KIND_EP) ? 4'd0 : top.cap);
                    board_d        = nb;
                    depth_d        = depth_q - 5'd1;
                    move_d         = top.mv;
                    cap_d          = top.cap;
                    out_captured_d = top.cap;
                    if (two_step(u_kind)) begin
                        state_d = STEP2;
                    end else begin
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                end
            end

            STEP2: begin
                if (!is_undo_q) begin
                    case (kind)
                        KIND_KING: begin
                            nb = set_sq(board_q, from_sq + 6'd1, sq(board_q, from_sq + 6'd3));
                            nb = set_sq(nb, from_sq + 6'd3, 4'd0);
                        end
                        KIND_QUEEN: begin
                            nb = set_sq(board_q, from_sq - 6'd1, sq(board_q, from_sq - 6'd4));
                            nb = set_sq(nb, from_sq - 6'd4, 4'd0);
                        end
                        default: nb = set_sq(board_q, ep_sq, 4'd0);
                    endcase
                    push_en        = 1'b1;
                    push_entry     = '{mv: move_q, cap: cap_q};
                    depth_d        = depth_q + 5'd1;
                    out_captured_d = cap_q;
                end else begin
                    case (kind)
                        KIND_KING: begin
                            nb = set_sq(board_q, from_sq + 6'd3, sq(board_q, from_sq + 6'd1));
                            nb = set_sq(nb, from_sq + 6'd1, 4'd0);
                        end
                        KIND_QUEEN: begin
                            nb = set_sq(board_q, from_sq - 6'd4, sq(board_q, from_sq - 6'd1));
                            nb = set_sq(nb, from_sq - 6'd1, 4'd0);
                        end
                        default: nb = set_sq(board_q, ep_sq, cap_q);
                    endcase
                end
                board_d     = nb;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end

            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            board_q        <= '0;
            depth_q        <= '0;
            is_undo_q      <= 1'b0;
            move_q         <= '0;
            cap_q          <= '0;
            out_captured_q <= '0;
            out_err_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            depth_q        <= depth_d;
            is_undo_q      <= is_undo_d;
            move_q         <= move_d;
            cap_q          <= cap_d;
            out_captured_q <= out_captured_d;
            out_err_q      <= out_err_d;
            out_valid_q    <= out_valid_d;
            in_ready_q     <= in_ready_d;
        end
    end

    // Stack storage needs no reset: entries above depth_q are never read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= push_entry;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_board    = board_q;
    assign bus.out_captured = out_captured_q;
    assign bus.out_err      = out_err_q;
    assign bus.depth        = depth_q;
endmodule

// File: tb/tb_move_apply.sv
// Table-driven bench for move_apply with a scoreboard queue, plus hand-written
// sequences for output back-pressure and reset in the middle of a castle.
module tb_move_apply;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    move_apply_if bus ();

    move_apply #(.STACK_DEPTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]   cmd;
        logic [17:0]  mv;
        logic [255:0] board_in;
        logic [255:0] exp_board;
        logic [3:0]   exp_cap;
        logic         exp_err;
        logic [4:0]   exp_depth;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic [255:0] exp_board;
        logic [3:0]   exp_cap;
        logic         exp_err;
        logic [4:0]   exp_depth;
        int           exp_lat;
    } exp_t;

    vec_t vecs [40];
    int   nvec = 0;
    exp_t sb [$];
    int   compared = 0;
    int   mismatched = 0;

    logic [255:0] start_b, kr_b, promo_b, ep_b;

    function automatic logic [255:0] put(input logic [255:0] b, input int s, input int p);
        b[s*4 +: 4] = 4'(p);
        return b;
    endfunction

    function automatic logic [17:0] mv(input int f, input int t, input int pr, input int k);
        return {6'(f), 6'(t), 3'(pr), 3'(k)};
    endfunction

    function automatic logic [255:0] startBoard();
        logic [255:0] b;
        int back [8];
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        b = '0;
        for (int f = 0; f < 8; f++) begin
            b = put(b, f, back[f]);
            b = put(b, 8 + f, 1);
            b = put(b, 48 + f, 9);
            b = put(b, 56 + f, 8 + back[f]);
        end
        return b;
    endfunction

    function automatic void addVec(input logic [1:0] cmd, input logic [17:0] m,
                                   input logic [255:0] bin, input logic [255:0] eb,
                                   input int ecap, input logic eerr, input int edepth,
                                   input int elat);
        vecs[nvec].cmd       = cmd;
        vecs[nvec].mv        = m;
        vecs[nvec].board_in  = bin;
        vecs[nvec].exp_board = eb;
        vecs[nvec].exp_cap   = 4'(ecap);
        vecs[nvec].exp_err   = eerr;
        vecs[nvec].exp_depth = 5'(edepth);
        vecs[nvec].exp_lat   = elat;
        nvec = nvec + 1;
    endfunction

    task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) checkVal("in_ready_wait", 256'(bus.in_ready), 256'd1);
        bus.in_valid = 1'b1;
        bus.in_cmd   = v.cmd;
        bus.in_move  = v.mv;
        bus.in_board = v.board_in;
        e.exp_board = v.exp_board;
        e.exp_cap   = v.exp_cap;
        e.exp_err   = v.exp_err;
        e.exp_depth = v.exp_depth;
        e.exp_lat   = v.exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_move  = 18'($urandom);
        bus.in_board = {8{$urandom}};
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) checkVal("out_valid_timeout", 256'(bus.out_valid), 256'd1);
    endtask

    task automatic checkOutput();
        exp_t e;
        int lat;
        waitResult(lat);
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 256'd0, 256'd1);
        end else begin
            e = sb.pop_front();
            checkVal("latency", 256'(lat), 256'(e.exp_lat));
            checkVal("board", bus.out_board, e.exp_board);
            checkVal("captured", 256'(bus.out_captured), 256'(e.exp_cap));
            checkVal("err", 256'(bus.out_err), 256'(e.exp_err));
            checkVal("depth", 256'(bus.depth), 256'(e.exp_depth));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // UNDO on an empty stack, then back-pressure for five cycles while a stray LOAD is offered.
    task automatic holdCheck();
        vec_t v;
        exp_t e;
        int lat;
        v.cmd = 2'd2; v.mv = '0; v.board_in = '0;
        v.exp_board = put('0, 0, 4); v.exp_cap = 4'd0; v.exp_err = 1'b1;
        v.exp_depth = 5'd0; v.exp_lat = 1;
        applyStimulus(v);
        waitResult(lat);
        e = sb.pop_front();
        checkVal("undo_empty_latency", 256'(lat), 256'(e.exp_lat));
        bus.in_valid = 1'b1;
        bus.in_cmd   = 2'd0;
        bus.in_board = start_b;
        for (int c = 0; c < 5; c++) begin
            checkVal("hold_valid", 256'(bus.out_valid), 256'd1);
            checkVal("hold_err", 256'(bus.out_err), 256'(e.exp_err));
            checkVal("hold_board", bus.out_board, e.exp_board);
            checkVal("hold_in_ready", 256'(bus.in_ready), 256'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkVal("release_in_ready", 256'(bus.in_ready), 256'd1);
        checkVal("release_out_valid", 256'(bus.out_valid), 256'd0);
        checkVal("release_depth", 256'(bus.depth), 256'd0);
    endtask

    // Reset lands while the castle is in STEP2; the king has already moved at that point.
    task automatic resetMidCastle();
        vec_t v;
        v.cmd = 2'd0; v.mv = '0; v.board_in = kr_b; v.exp_board = kr_b;
        v.exp_cap = 4'd0; v.exp_err = 1'b0; v.exp_depth = 5'd0; v.exp_lat = 1;
        applyStimulus(v);
        checkOutput();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_cmd   = 2'd1;
        bus.in_move  = mv(4, 6, 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkVal("rst_board", bus.out_board, 256'd0);
        checkVal("rst_depth", 256'(bus.depth), 256'd0);
        checkVal("rst_out_valid", 256'(bus.out_valid), 256'd0);
        checkVal("rst_err", 256'(bus.out_err), 256'd0);
        @(negedge clk);
        reset = 1'b0;
        v.board_in = start_b; v.exp_board = start_b;
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cmd   = 2'd0;
        bus.in_move  = '0;
        bus.in_board = '0;
        bus.out_ready = 1'b0;

        start_b = startBoard();
        kr_b    = put(put('0, 4, 6), 7, 4);
        promo_b = put(put('0, 52, 1), 61, 4'hA);
        ep_b    = put(put('0, 36, 1), 35, 4'h9);

        addVec(2'd0, '0, start_b, start_b, 0, 1'b0, 0, 1);
        addVec(2'd1, mv(12, 28, 0, 0), '0, put(put(start_b, 12, 0), 28, 1), 0, 1'b0, 1, 2);
        addVec(2'd3, '0, kr_b, kr_b, 0, 1'b0, 0, 1);
        addVec(2'd1, mv(4, 6, 0, 1), '0, put(put('0, 6, 6), 5, 4), 0, 1'b0, 1, 3);
        addVec(2'd2, '0, '0, kr_b, 0, 1'b0, 0, 3);
        addVec(2'd0, '0, promo_b, promo_b, 0, 1'b0, 0, 1);
        addVec(2'd1, mv(52, 61, 5, 0), '0, put('0, 61, 5), 4'hA, 1'b0, 1, 2);
        addVec(2'd2, '0, '0, promo_b, 4'hA, 1'b0, 0, 2);
        addVec(2'd0, '0, ep_b, ep_b, 0, 1'b0, 0, 1);
        addVec(2'd1, mv(36, 43, 0, 3), '0, put('0, 43, 1), 4'h9, 1'b0, 1, 3);
        addVec(2'd2, '0, '0, ep_b, 4'h9, 1'b0, 0, 3);
        addVec(2'd0, '0, put('0, 0, 4), put('0, 0, 4), 0, 1'b0, 0, 1);
        for (int i = 0; i < 8; i++)
            addVec(2'd1, mv(i, i + 1, 0, 0), '0, put('0, i + 1, 4), 0, 1'b0, i + 1, 2);
        addVec(2'd1, mv(8, 9, 0, 0), '0, put('0, 8, 4), 0, 1'b1, 8, 1);
        for (int j = 0; j < 8; j++)
            addVec(2'd2, '0, '0, put('0, 7 - j, 4), 0, 1'b0, 7 - j, 2);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkVal("reset_in_ready", 256'(bus.in_ready), 256'd1);
        checkVal("reset_out_valid", 256'(bus.out_valid), 256'd0);
        checkVal("reset_board", bus.out_board, 256'd0);
        checkVal("reset_depth", 256'(bus.depth), 256'd0);
        checkVal("reset_captured", 256'(bus.out_captured), 256'd0);

        for (int k = 0; k < nvec; k++) begin
            applyStimulus(vecs[k]);
            checkOutput();
        end

        holdCheck();
        resetMidCastle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/move_apply.md
MOVE_APPLY -- requirements
Module: move_apply

Interface
REQ-001 Parameter STACK_DEPTH, default 8, is the number of undo entries held (power of two, 2..16).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  command present.
REQ-005 in_ready  out  1  block can accept a command; high only in IDLE.
REQ-006 in_cmd  in  2  command: 0 LOAD, 1 DO, 2 UNDO; 3 is reserved and is treated as LOAD.
REQ-007 in_move  in  18  move word {from[17:12], to[11:6], promo[5:3], kind[2:0]}; kind: 0 normal, 1 king-side castle, 2 queen-side castle, 3 en passant.
REQ-008 in_board  in  256  board for LOAD; square i = bits [4i+3:4i], i = rank*8+file; piece code: 0 empty, bit3 = black, low3: 1 P, 2 N, 3 B, 4 R, 5 Q, 6 K.
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 out_board  out  256  current board register.
REQ-012 out_captured  out  4  piece removed by last DO, or restored by last UNDO.
REQ-013 out_err  out  1  last command rejected; qualified by out_valid.
REQ-014 depth  out  5  number of entries on the undo stack.

Function
REQ-015 The block SHALL hold a 256-bit board register and a LIFO of {move, captured[3:0]} entries.
REQ-016 The state machine SHALL use states IDLE, STEP1, STEP2 and OUT; a command is accepted on in_valid && in_ready.
REQ-017 LOAD SHALL copy in_board to the board, clear the stack (depth = 0), set out_captured = 0, and go IDLE -> OUT, giving out_valid 1 cycle after accept.
REQ-018 DO in STEP1 SHALL capture: cap = board[to] (kind 3: cap = board[from rank*8 + to file]); board[to] = promo != 0 ? {board[from][3], promo} : board[from]; board[from] = 0.
REQ-019 DO kind 1 SHALL, in STEP2, move the rook from from+3 to from+1; kind 2 SHALL move it from from-4 to from-1; kind 3 SHALL clear the en-passant capture square in STEP2.
REQ-020 DO SHALL push {move, cap} on the last step and set out_captured = cap.
REQ-021 DO latency SHALL be 2 cycles from accept to out_valid for kind 0, and 3 cycles for kinds 1, 2 and 3.
REQ-022 UNDO SHALL pop the top entry in STEP1 and restore: board[from] = promo != 0 ? {board[to][3], 3'd1} : board[to]; board[to] = (kind 3) ? 0 : cap.
REQ-023 UNDO of kinds 1, 2 and 3 SHALL, in STEP2, move the rook back or restore cap to the en-passant square; latency SHALL equal that of DO.
REQ-024 DO with depth == STACK_DEPTH, or UNDO with depth == 0, SHALL leave the board and stack unchanged and go directly to OUT with out_err = 1 (latency 1).
REQ-025 out_valid and out_err SHALL stay high and stable in OUT until out_ready, then the block returns to IDLE on the next edge.
REQ-026 out_ready while out_valid = 0 SHALL be ignored; in_valid outside IDLE SHALL be ignored; in_move is sampled only at accept.
REQ-027 No legality checking SHALL be performed; square arithmetic SHALL be 6-bit modulo 64.

Reset
REQ-028 On reset assertion, at any time including mid-command: state = IDLE, board = 0, depth = 0, out_valid = 0, out_err = 0, out_captured = 0, and in_ready = 1 from the first edge after reset release.
REQ-029 A command in flight at reset SHALL be discarded, with no partial board update retained.

Verification
REQ-030 LOAD the start position, then DO {12, 28, 0, 0} -> out_valid 2 cycles after accept, square 28 = 4'h1, square 12 = 0, depth = 1, out_captured = 0.
REQ-031 Board with white K at 4 and white R at 7, DO {4, 6, 0, 1} -> after 3 cycles, sq6 = 4'h6, sq5 = 4'h4, sq4 = sq7 = 0; then UNDO restores the original board exactly, with depth = 0.
REQ-032 White P at 52 and black N at 61, DO {52, 61, 5, 0} -> sq61 = 4'h5, out_captured = 4'hA; UNDO -> sq52 = 4'h1, sq61 = 4'hA.
REQ-033 En passant: white P at 36 and black P at 35, DO {36, 43, 0, 3} -> sq43 = 4'h1, sq35 = 0, out_captured = 4'h9; UNDO restores sq35 = 4'h9.
REQ-034 Perform 8 DOs, then a 9th -> out_err = 1, board unchanged, depth = 8; UNDO at depth 0 -> out_err = 1; hold out_ready = 0 for 5 cycles -> outputs stable throughout.
REQ-035 Assert reset during STEP2 of a castle -> board = 0, depth = 0, out_valid = 0, and the next LOAD is accepted normally.
